// File: rtl/decode_exec_mem_pkg.sv
// Shared definitions for the decode/execute/memory slice.
// Includes RV32I opcodes, ALU op codes (funct3), debug codes and the decoded control bundle.
package decode_exec_mem_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [2:0]  F3_WORD      = 3'b010;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      DBG_NONE    = 2'b00,
      DBG_EBREAK  = 2'b01,
      DBG_ILLEGAL = 2'b10
   } debug_e;

   typedef struct packed {
      alu_op_e     op;
      logic        neg;
      logic        mod;
      logic        use_imm;
      logic [31:0] imm;
      logic        zero_rs1;
      logic        rd_we;
      logic        is_load;
      logic        is_store;
      debug_e      debug;
   } ctrl_t;

endpackage

// File: rtl/rv_alu.sv
// RV32I integer ALU; op is funct3, neg selects subtract, mod selects arithmetic right shift.
module rv_alu
   import decode_exec_mem_pkg::*;
(
   input  alu_op_e     op,
   input  logic        neg,
   input  logic        mod,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      res = '0;
      case (op)
         F3_ADD:  res = neg ? a - b : a + b;
         F3_SLL:  res = a << shamt;
         F3_SLT:  res = {31'b0, $signed(a) < $signed(b)};
         F3_SLTU: res = {31'b0, a < b};
         F3_XOR:  res = a ^ b;
         F3_SR:   res = mod ? 32'($signed(a) >>> shamt) : a >> shamt;
         F3_OR:   res = a | b;
         F3_AND:  res = a & b;
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder for the supported subset.
// Any encoding outside that subset is flagged as illegal.
module rv_decoder
   import decode_exec_mem_pkg::*;
(
   input  logic [31:0] instruction,
   output ctrl_t       ctrl
);

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   alu_op_e     f3;
   logic [31:0] imm_i;
   logic [31:0] imm_s;

   assign opcode = instruction[6:0];
   assign funct7 = instruction[31:25];
   assign f3     = alu_op_e'(instruction[14:12]);
   assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};

   always_comb begin
      // NOTE: the whole bundle is defaulted first so no path through the case infers a latch.
      ctrl       = '0;
      ctrl.op    = f3;
      ctrl.debug = DBG_ILLEGAL;
      case (opcode)
         OPC_OP: begin
            ctrl.neg = (f3 == F3_ADD) && funct7[5];
            ctrl.mod = (f3 == F3_SR) && funct7[5];
            if (funct7 == 7'h00 || (funct7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR))) begin
               ctrl.rd_we = 1'b1;
               ctrl.debug = DBG_NONE;
            end
         end
         OPC_OP_IMM: begin
            ctrl.use_imm = 1'b1;
            ctrl.imm     = imm_i;
            ctrl.mod     = (f3 == F3_SR) && funct7[5];
            // Shift-immediates reuse imm[11:5] as funct7, so only those two forms are checked.
            if (!((f3 == F3_SLL && funct7 != 7'h00) ||
                  (f3 == F3_SR && funct7 != 7'h00 && funct7 != 7'h20))) begin
               ctrl.rd_we = 1'b1;
               ctrl.debug = DBG_NONE;
            end
         end
         OPC_LUI: begin
            ctrl.op       = F3_ADD;
            ctrl.use_imm  = 1'b1;
            ctrl.imm      = {instruction[31:12], 12'b0};
            ctrl.zero_rs1 = 1'b1;
            ctrl.rd_we    = 1'b1;
            ctrl.debug    = DBG_NONE;
         end
         OPC_LOAD: begin
            if (instruction[14:12] == F3_WORD) begin
               ctrl.op      = F3_ADD;
               ctrl.use_imm = 1'b1;
               ctrl.imm     = imm_i;
               ctrl.is_load = 1'b1;
               ctrl.rd_we   = 1'b1;
               ctrl.debug   = DBG_NONE;
            end
         end
         OPC_STORE: begin
            if (instruction[14:12] == F3_WORD) begin
               ctrl.op       = F3_ADD;
               ctrl.use_imm  = 1'b1;
               ctrl.imm      = imm_s;
               ctrl.is_store = 1'b1;
               ctrl.debug    = DBG_NONE;
            end
         end
         OPC_SYSTEM: begin
            if (instruction == INSTR_EBREAK) ctrl.debug = DBG_EBREAK;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/word_dmem.sv
// Word-addressed data memory: combinational read, write on the rising clock edge.
module word_dmem #(
   parameter int unsigned WORDS = 1024,
   localparam int unsigned AW   = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // NOTE: the array has no reset so it maps onto RAM; contents survive rst by design.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/decode_exec_mem.sv
// Single-cycle RV32I decode/execute/memory slice between instruction memory and register file.
// Only data-memory writes and the sticky halted flag are clocked.
module decode_exec_mem
   import decode_exec_mem_pkg::*;
#(
   parameter int unsigned DMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [4:0]  rs1_idx,
   output logic [4:0]  rs2_idx,
   output logic [4:0]  rd_idx,
   output logic [31:0] rd_data,
   output logic        rd_we,
   output logic [1:0]  debug
);

   localparam int unsigned AW = $clog2(DMEM_WORDS);

   ctrl_t       ctrl;
   logic        halted;
   logic        active;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_res;
   logic [31:0] mem_rdata;

   rv_decoder u_dec (
      .instruction(instruction),
      .ctrl       (ctrl)
   );

   assign a = ctrl.zero_rs1 ? '0 : rs1_data;
   assign b = ctrl.use_imm ? ctrl.imm : rs2_data;

   rv_alu u_alu (
      .op (ctrl.op),
      .neg(ctrl.neg),
      .mod(ctrl.mod),
      .a  (a),
      .b  (b),
      .res(alu_res)
   );

   assign active = !rst && !halted;

   // Byte offset addr[1:0] is dropped and bits above the memory size wrap.
   word_dmem #(.WORDS(DMEM_WORDS)) u_mem (
      .clk  (clk),
      .we   (active && ctrl.is_store),
      .addr (alu_res[AW+1:2]),
      .wdata(rs2_data),
      .rdata(mem_rdata)
   );

   assign rs1_idx = ctrl.zero_rs1 ? 5'd0 : instruction[19:15];
   assign rs2_idx = instruction[24:20];
   assign rd_idx  = instruction[11:7];
   assign rd_data = ctrl.is_load ? mem_rdata : alu_res;
   assign rd_we   = active && ctrl.rd_we;
   assign debug   = ctrl.debug;

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignment so every reader sees the pre-edge value.
      if (rst) begin
         halted <= 1'b0;
      end else if (ctrl.debug != DBG_NONE) begin
         halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_exec_mem.sv
// Directed self-checking bench for decode_exec_mem with hand-computed expected values.
module tb_decode_exec_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruction = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [4:0]  rd_idx;
   logic [31:0] rd_data;
   logic        rd_we;
   logic [1:0]  debug;

   int n_vec = 0;
   int n_bad = 0;

   decode_exec_mem #(.DMEM_WORDS(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .instruction(instruction),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .rs1_idx    (rs1_idx),
      .rs2_idx    (rs2_idx),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_we      (rd_we),
      .debug      (debug)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      rst         = r;
      instruction = ins;
      rs1_data    = a;
      rs2_data    = b;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset: writes blocked while rst is high.
      step(1'b1, 32'h0050_0093, 32'h0, 32'h0);
      check("rst_rd_we", rd_we, 1'b0);
      check("rst_debug", debug, 2'b00);

      step(1'b0, 32'h0050_0093, 32'h0, 32'h0);            // ADDI x1,x0,5
      check("addi_data", rd_data, 32'h5);
      check("addi_rd_idx", rd_idx, 5'd1);
      check("addi_we", rd_we, 1'b1);
      check("addi_debug", debug, 2'b00);

      step(1'b0, 32'hFFF0_0093, 32'h3, 32'h0);            // ADDI x1,x0,-1 with rs1_data=3
      check("addi_neg_imm", rd_data, 32'h2);

      step(1'b0, 32'h4020_81B3, 32'h3, 32'h5);            // SUB x3,x1,x2
      check("sub_data", rd_data, 32'hFFFF_FFFE);
      check("sub_rs1_idx", rs1_idx, 5'd1);
      check("sub_rs2_idx", rs2_idx, 5'd2);

      step(1'b0, 32'h4020_D1B3, 32'h8000_0000, 32'h4);    // SRA
      check("sra_data", rd_data, 32'hF800_0000);
      step(1'b0, 32'h0020_D1B3, 32'h8000_0000, 32'h4);    // SRL
      check("srl_data", rd_data, 32'h0800_0000);
      step(1'b0, 32'h4040_D093, 32'h8000_0000, 32'h0);    // SRAI x1,x1,4
      check("srai_data", rd_data, 32'hF800_0000);
      step(1'b0, 32'h0020_B1B3, 32'h1, 32'hFFFF_FFFF);    // SLTU
      check("sltu_data", rd_data, 32'h1);
      step(1'b0, 32'h0020_A1B3, 32'h1, 32'hFFFF_FFFF);    // SLT
      check("slt_data", rd_data, 32'h0);

      step(1'b0, 32'h0020_A023, 32'h10, 32'hDEAD_BEEF);   // SW x2,0(x1)
      check("sw_we", rd_we, 1'b0);
      check("sw_debug", debug, 2'b00);
      step(1'b0, 32'h0000_A203, 32'h13, 32'h0);           // LW x4,0(x1), addr 0x13
      check("lw_data", rd_data, 32'hDEAD_BEEF);
      check("lw_we", rd_we, 1'b1);
      step(1'b0, 32'h0040_A203, 32'hC, 32'h0);            // LW x4,4(x1), addr 0x10
      check("lw_imm_data", rd_data, 32'hDEAD_BEEF);
      step(1'b0, 32'h0000_A203, 32'h1010, 32'h0);         // address wraps onto word 4
      check("lw_wrap_data", rd_data, 32'hDEAD_BEEF);

      step(1'b1, 32'h0020_A023, 32'h10, 32'h1234_5678);   // SW under reset
      check("sw_rst_we", rd_we, 1'b0);
      step(1'b0, 32'h0000_A203, 32'h10, 32'h0);
      check("sw_rst_kept", rd_data, 32'hDEAD_BEEF);

      step(1'b0, 32'h0000_0000, 32'h0, 32'h0);            // all-zero word
      check("zero_debug", debug, 2'b10);
      check("zero_we", rd_we, 1'b0);
      step(1'b0, 32'h0220_81B3, 32'h1, 32'h2);            // ADD with funct7=0x01
      check("add_f7_debug", debug, 2'b10);
      check("add_f7_we", rd_we, 1'b0);
      step(1'b0, 32'h0210_D093, 32'h1, 32'h0);            // SRLI with funct7=0x01
      check("srli_f7_debug", debug, 2'b10);
      step(1'b0, 32'h0020_A023, 32'h10, 32'hCAFE_F00D);   // SW while halted
      check("halt_sw_debug", debug, 2'b00);
      step(1'b0, 32'h0050_0093, 32'h0, 32'h0);
      check("halt_addi_we", rd_we, 1'b0);
      step(1'b1, 32'h0050_0093, 32'h0, 32'h0);
      step(1'b0, 32'h0000_A203, 32'h10, 32'h0);
      check("halt_sw_blocked", rd_data, 32'hDEAD_BEEF);
      check("unhalt_lw_we", rd_we, 1'b1);

      step(1'b0, 32'h0010_0073, 32'h0, 32'h0);            // EBREAK
      check("ebreak_debug", debug, 2'b01);
      check("ebreak_we", rd_we, 1'b0);
      step(1'b0, 32'h0050_0093, 32'h0, 32'h0);
      check("post_ebreak_we", rd_we, 1'b0);
      check("post_ebreak_debug", debug, 2'b00);
      step(1'b1, 32'h0050_0093, 32'h0, 32'h0);
      step(1'b0, 32'h0050_0093, 32'h0, 32'h0);
      check("after_rst_we", rd_we, 1'b1);
      check("after_rst_data", rd_data, 32'h5);

      step(1'b0, 32'h1234_5137, 32'h0, 32'h0);            // LUI x2,0x12345
      check("lui_data", rd_data, 32'h1234_5000);
      check("lui_rs1_idx", rs1_idx, 5'd0);
      check("lui_rd_idx", rd_idx, 5'd2);
      check("lui_we", rd_we, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
